// File: rtl/cbx_pkg.sv
// cbx_pkg: shared definitions for the connection-block configuration chain.
//   cbx_state_t  - configuration FSM state encoding
//   cbx_clog2()  - ceiling log2, used for mux select width and counter width
package cbx_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      LOADED  = 2'd2,
      OVERRUN = 2'd3
   } cbx_state_t;

   // Smallest w with 2**w >= value (0 for value <= 1).
   function automatic int unsigned cbx_clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int unsigned k = 0; k < 32; k++) begin
         if ((64'd1 << k) < 64'(value)) w = k + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/cbx_ipin_mux.sv
// cbx_ipin_mux: one grid input-pin multiplexer.
//   mux_in  [MUX_SIZE] - candidate track values
//   sel     [SEL_W]    - configured select; codes >= MUX_SIZE give 0
//   mux_out [1]        - selected value
module cbx_ipin_mux
   import cbx_pkg::*;
#(
   parameter int unsigned MUX_SIZE = 12,
   parameter int unsigned SEL_W    = cbx_clog2(MUX_SIZE)
) (
   input  logic [MUX_SIZE-1:0] mux_in,
   input  logic [SEL_W-1:0]    sel,
   output logic                mux_out
);

   always_comb begin
      mux_out = 1'b0;
      if (32'(sel) < MUX_SIZE) mux_out = mux_in[sel];
   end

endmodule

// File: rtl/cbx_param_chain.sv
// cbx_param_chain: connection block with a serial configuration chain.
//   prog_clk, pReset_n          - config clock, async active-low reset
//   ccff_head, ccff_en          - serial config data in, shift enable
//   ccff_rb                     - rotate (readback) shift, only with CBX_READBACK_EN
//   chanx_left_in/right_in      - channel tracks [CHAN_W]
//   chanx_left_out/right_out    - combinational pass-through tracks [CHAN_W]
//   ipin_out [NUM_IPIN]         - grid pin drives, live only in LOADED
//   ccff_tail                   - serial config data out (top chain bit)
//   cfg_done, cfg_err           - exactly-loaded / sticky overrun flags
// Optional feature: define CBX_READBACK_EN to add ccff_rb and rotate shifts.
module cbx_param_chain
   import cbx_pkg::*;
#(
   parameter int unsigned CHAN_W   = 30,
   parameter int unsigned NUM_IPIN = 4,
   parameter int unsigned MUX_SIZE = 12,
   parameter int unsigned STRIDE   = 3
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              ccff_head,
   input  logic              ccff_en,
`ifdef CBX_READBACK_EN
   input  logic              ccff_rb,
`endif
   input  logic [CHAN_W-1:0] chanx_left_in,
   input  logic [CHAN_W-1:0] chanx_right_in,
   output logic [CHAN_W-1:0] chanx_left_out,
   output logic [CHAN_W-1:0] chanx_right_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic              ccff_tail,
   output logic              cfg_done,
   output logic              cfg_err
);

   localparam int unsigned SEL_W = cbx_clog2(MUX_SIZE);
   localparam int unsigned L     = NUM_IPIN * SEL_W;
   localparam int unsigned CNT_W = cbx_clog2(L + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(L);

   logic [L-1:0]        chain;
   logic [CNT_W-1:0]    cnt;
   cbx_state_t          state, state_next;
   logic                rotate, load_shift, shift_in, ipin_en;
   logic [NUM_IPIN-1:0] mux_out;

   assign chanx_right_out = chanx_left_in;
   assign chanx_left_out  = chanx_right_in;

`ifdef CBX_READBACK_EN
   assign rotate = ccff_en & ccff_rb;
`else
   assign rotate = 1'b0;
`endif
   assign load_shift = ccff_en & ~rotate;
   // Rotate shifts recirculate the top bit so the stream replays on ccff_tail.
   assign shift_in   = rotate ? chain[L-1] : ccff_head;
   assign ccff_tail  = chain[L-1];

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         chain <= '0;
         cnt   <= '0;
      end else if (ccff_en) begin
         chain <= {chain[L-2:0], shift_in};
         if (load_shift && (cnt != CNT_FULL)) cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) state <= EMPTY;
      else           state <= state_next;
   end

   always_comb begin
      state_next = state;
      cfg_done   = 1'b0;
      cfg_err    = 1'b0;
      ipin_en    = 1'b0;
      case (state)
         EMPTY, LOADING: begin
            if (load_shift)
               state_next = (cnt == CNT_FULL - 1'b1) ? LOADED : LOADING;
         end
         LOADED: begin
            cfg_done = 1'b1;
            ipin_en  = 1'b1;
            if (load_shift) state_next = OVERRUN;
         end
         OVERRUN: cfg_err = 1'b1;
         default: state_next = EMPTY;
      endcase
   end

   for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
      logic [MUX_SIZE-1:0] mux_in;
      for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_pair
         localparam int unsigned T = (i + j * STRIDE) % CHAN_W;
         assign mux_in[2*j]   = chanx_left_in[T];
         assign mux_in[2*j+1] = chanx_right_in[T];
      end
      cbx_ipin_mux #(
         .MUX_SIZE (MUX_SIZE),
         .SEL_W    (SEL_W)
      ) u_mux (
         .mux_in  (mux_in),
         .sel     (chain[i*SEL_W +: SEL_W]),
         .mux_out (mux_out[i])
      );
   end

   assign ipin_out = mux_out & {NUM_IPIN{ipin_en}};

endmodule

// File: tb/tb_cbx_param_chain.sv
// tb_cbx_param_chain: scoreboard bench for cbx_param_chain with default parameters.
// Define CBX_READBACK_EN to also exercise rotate shifts.
module tb_cbx_param_chain;

   logic        prog_clk = 1'b0;
   logic        pReset_n, ccff_head, ccff_en;
`ifdef CBX_READBACK_EN
   logic        ccff_rb;
`endif
   logic [29:0] left_in, right_in, left_out, right_out;
   logic [3:0]  ipin;
   logic        tail, done, err;

   typedef struct {
      string       name;
      logic        done, err, tail;
      logic [3:0]  ipin, ipin_mask;
      logic [29:0] l_out, r_out;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 prog_clk = ~prog_clk;

   cbx_param_chain #(
      .CHAN_W   (30),
      .NUM_IPIN (4),
      .MUX_SIZE (12),
      .STRIDE   (3)
   ) dut (
      .prog_clk        (prog_clk),
      .pReset_n        (pReset_n),
      .ccff_head       (ccff_head),
      .ccff_en         (ccff_en),
`ifdef CBX_READBACK_EN
      .ccff_rb         (ccff_rb),
`endif
      .chanx_left_in   (left_in),
      .chanx_right_in  (right_in),
      .chanx_left_out  (left_out),
      .chanx_right_out (right_out),
      .ipin_out        (ipin),
      .ccff_tail       (tail),
      .cfg_done        (done),
      .cfg_err         (err)
   );

   // Monitor: every falling edge, compare the DUT against all queued expectations.
   initial begin
      exp_t x;
      forever begin
         @(negedge prog_clk);
         while (q.size() > 0) begin
            x = q.pop_front();
            n_checks++;
            if ({done, err, tail, ipin & x.ipin_mask} !==
                {x.done, x.err, x.tail, x.ipin & x.ipin_mask}) begin
               n_fail++;
               $display("FAIL %s: done/err/tail/ipin got %b/%b/%b/%b expected %b/%b/%b/%b (mask %b)",
                        x.name, done, err, tail, ipin, x.done, x.err, x.tail, x.ipin, x.ipin_mask);
            end
            n_checks++;
            if ({left_out, right_out} !== {x.l_out, x.r_out}) begin
               n_fail++;
               $display("FAIL %s_passthru: left_out/right_out got %h/%h expected %h/%h",
                        x.name, left_out, right_out, x.l_out, x.r_out);
            end
         end
      end
   end

   task automatic chk(input string name, input logic d, input logic e, input logic t,
                      input logic [3:0] ip, input logic [3:0] mask);
      exp_t x;
      x.name = name; x.done = d; x.err = e; x.tail = t;
      x.ipin = ip; x.ipin_mask = mask;
      x.l_out = right_in; x.r_out = left_in;
      q.push_back(x);
      @(negedge prog_clk); #1;
   endtask

   task automatic shift(input logic b);
      ccff_head = b;
      ccff_en   = 1'b1;
      @(posedge prog_clk); #1;
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

`ifdef CBX_READBACK_EN
   task automatic rotate_shift();
      ccff_rb = 1'b1;
      ccff_en = 1'b1;
      @(posedge prog_clk); #1;
      ccff_en = 1'b0;
      ccff_rb = 1'b0;
   endtask
`endif

   // Shift bits v[hi] down to v[lo]; v[15] of a full load ends up in chain bit 15.
   task automatic load(input logic [15:0] v, input int hi, input int lo);
      for (int k = hi; k >= lo; k--) shift(v[k]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge prog_clk);
      #1;
   endtask

   // Reset asserted between clock edges and checked before any further edge.
   task automatic do_reset(input string name);
      #1 pReset_n = 1'b0;
      #1 chk(name, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
      pReset_n = 1'b1;
   endtask

   initial begin
      pReset_n  = 1'b0;
      ccff_head = 1'b0;
      ccff_en   = 1'b0;
`ifdef CBX_READBACK_EN
      ccff_rb   = 1'b0;
`endif
      left_in   = '0;
      right_in  = '0;
      @(posedge prog_clk); #1;

      left_in  = 30'h2AAAAAAA;
      right_in = 30'h15555555;
      chk("reset", 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
      pReset_n = 1'b1;

      // sel[0]=5 (right track 6), sel[1..3]=0 (left tracks 1..3)
      left_in  = '1;
      right_in = '1;
      load(16'h0005, 15, 1);
      chk("partial15", 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
      load(16'h0005, 0, 0);
      chk("load16_all_ones", 1'b1, 1'b0, 1'b0, 4'b1111, 4'hF);
      left_in  = '0;
      right_in = 30'h00000040;
      chk("sel5_right6", 1'b1, 1'b0, 1'b0, 4'b0001, 4'hF);
      left_in  = 30'h0000000E;
      right_in = '0;
      chk("sel0_left1to3", 1'b1, 1'b0, 1'b0, 4'b1110, 4'hF);
      idle(3);
      chk("hold_en_low", 1'b1, 1'b0, 1'b0, 4'b1110, 4'hF);

      left_in  = '1;
      right_in = '1;
      shift(1'b0);
      chk("overrun17", 1'b0, 1'b1, 1'b0, 4'h0, 4'hF);
      shift(1'b1);
      chk("overrun_sticky", 1'b0, 1'b1, 1'b0, 4'h0, 4'hF);
      idle(2);
      chk("overrun_idle", 1'b0, 1'b1, 1'b0, 4'h0, 4'hF);
      do_reset("reset_after_overrun");

      // Eight ones then reset mid-load; the next load must need all 16 shifts.
      load(16'hFFFF, 15, 8);
      do_reset("midload_reset");
      // sel[2]=13 is out of range, sel[3]=8 picks left track 15
      load(16'h8D00, 15, 1);
      chk("reload15", 1'b0, 1'b0, 1'b0, 4'h0, 4'hF);
      load(16'h8D00, 0, 0);
      chk("sel2_out_of_range", 1'b1, 1'b0, 1'b1, 4'b1011, 4'hF);

      // sel[0]=4 picks left track 6 only
      do_reset("reset_before_sel4");
      load(16'h0004, 15, 0);
      left_in  = 30'h00000040;
      right_in = '0;
      chk("sel4_left6", 1'b1, 1'b0, 1'b0, 4'b0001, 4'hF);
      left_in  = '0;
      right_in = 30'h00000040;
      chk("sel4_right6_ignored", 1'b1, 1'b0, 1'b0, 4'b0000, 4'hF);

`ifdef CBX_READBACK_EN
      begin
         logic [15:0] r;
         do_reset("reset_before_readback");
         left_in  = '1;
         right_in = '1;
         load(16'h8D00, 15, 0);
         r = 16'h8D00;
         for (int k = 0; k < 16; k++) begin
            rotate_shift();
            r = {r[14:0], r[15]};
            chk($sformatf("rotate_%0d", k), 1'b1, 1'b0, r[15], 4'h0, 4'h0);
         end
         chk("rotate_restored", 1'b1, 1'b0, 1'b1, 4'b1011, 4'hF);
         shift(1'b0);
         chk("overrun_after_rotate", 1'b0, 1'b1, 1'b0, 4'h0, 4'hF);
      end
`endif

      @(negedge prog_clk); #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
